// File: rtl/axi_dma_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write DMA master and its memory-side slave.
interface axi_dma_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH/8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_dma_wr.sv
// Single-channel AXI4 write DMA: one command -> one INCR burst fed from an AXI-Stream.
// Define AXI_DMA_WR_4K_CHECK_EN to reject commands whose burst would cross a 4 KB page.
module axi_dma_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  axi_dma_wr_if.master          m_axi,
  output logic                  sts_valid,
  output logic [1:0]            sts_resp,
  output logic                  busy
);
  localparam int SIZE = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } cmd_t;

  state_t                state;
  cmd_t                  cmd_q;
  logic [8:0]            beat_cnt;
  logic                  awvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic                  in_data;
  logic                  w_hs;
  logic                  last_beat;
  logic                  crosses_4k;
  logic                  unused_bid;

  assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH-1);

`ifdef AXI_DMA_WR_4K_CHECK_EN
  assign crosses_4k = ((32'(cmd_addr_al) & 32'hFFF) +
                       (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH)) > 32'd4096;
`else
  assign crosses_4k = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      sts_valid <= 1'b0;
      sts_resp  <= 2'b00;
      busy      <= 1'b0;
      cmd_q     <= '0;
      beat_cnt  <= '0;
    end else begin
      sts_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (crosses_4k) begin
              sts_valid <= 1'b1;
              sts_resp  <= 2'b10;
            end else begin
              cmd_q     <= '{addr: cmd_addr_al, len: cmd_len};
              beat_cnt  <= '0;
              awvalid_q <= 1'b1;
              busy      <= 1'b1;
              state     <= ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) begin
              bready_q <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            bready_q  <= 1'b0;
            sts_valid <= 1'b1;
            sts_resp  <= m_axi.bresp;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // W is a straight pass-through of the stream, gated to the DATA phase only
  assign in_data   = (state == DATA);
  assign w_hs      = in_data && s_axis_tvalid && m_axi.wready;
  assign last_beat = (beat_cnt == {1'b0, cmd_q.len});

  assign m_axi.wdata   = s_axis_tdata;
  assign m_axi.wvalid  = in_data && s_axis_tvalid;
  assign m_axi.wlast   = in_data && last_beat;
  assign m_axi.wstrb   = '1;
  assign s_axis_tready = in_data && m_axi.wready;

  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = cmd_q.addr;
  assign m_axi.awlen   = cmd_q.len;
  assign m_axi.awsize  = 3'(SIZE);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.bready  = bready_q;

  assign unused_bid = ^m_axi.bid;
endmodule

// File: tb/tb_axi_dma_wr.sv
// Scoreboard bench for axi_dma_wr: random stream gaps and slave stalls against a queue-based model.
module tb_axi_dma_wr;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          sts_valid;
  logic [1:0]    sts_resp;
  logic          busy;

  always #5 clk = ~clk;

  axi_dma_wr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

  axi_dma_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(DW/8), .ID_WIDTH(IW), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .m_axi(axi),
    .sts_valid(sts_valid), .sts_resp(sts_resp), .busy(busy)
  );

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;
  typedef struct { logic [1:0] resp; bit rej; } sts_exp_t;

  aw_exp_t       q_aw[$];
  w_exp_t        q_w[$];
  sts_exp_t      q_sts[$];
  logic [DW-1:0] q_data[$];
  logic [1:0]    q_bresp[$];
  logic [DW-1:0] exp_mem[int];
  logic [DW-1:0] ram[int];

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  int beats_seen = 0, sts_cnt = 0, exp_sts_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return ram.exists(k) ? ram[k] : 'x;
  endfunction

  // Reference rule: a burst is refused when it would run past the end of its 4 KB page
  function automatic bit rejects(input logic [AW-1:0] a, input int len);
`ifdef AXI_DMA_WR_4K_CHECK_EN
    int base = int'(a) / 4 * 4;
    return (base % 4096) + (len + 1) * 4 > 4096;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: random data, 1: beat index, 2: 0xDEADBEEF + index
  task automatic issue(input logic [AW-1:0] a, input int len, input logic [1:0] resp,
                       input int mode, input bit track);
    int base = int'(a) / 4 * 4;
    logic [DW-1:0] d;
    bit got = 0;
    if (rejects(a, len)) begin
      q_sts.push_back('{2'b10, 1'b1});
    end else begin
      q_aw.push_back('{AW'(base), 8'(len)});
      for (int i = 0; i <= len; i++) begin
        d = (mode == 1) ? DW'(i) : (mode == 2) ? 32'hDEADBEEF + DW'(i) : DW'($urandom);
        q_w.push_back('{d, i == len});
        q_data.push_back(d);
        if (track) exp_mem[base/4 + i] = d;
      end
      q_bresp.push_back(resp);
      q_sts.push_back('{resp, 1'b0});
    end
    exp_sts_total++;
    cmd_addr = a; cmd_len = 8'(len); cmd_valid = 1'b1;
    for (int t = 0; t < 5000 && !got; t++) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
    end
    chk("cmd_accept_timeout", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((q_sts.size() != 0 || q_w.size() != 0) && t < 20000) begin
      @(posedge clk); t++;
    end
    chk("done_timeout", t < 20000, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or status
  initial begin
    aw_exp_t ea; w_exp_t ew; sts_exp_t es;
    bit aw_done = 0;
    int outstanding = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_done = 0; outstanding = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          chk("cmd_overlap", outstanding, 0);
          outstanding++;
          acc_cyc = cyc;
        end
        if (axi.awvalid) chk("aw_during_data_resp", {axi.wvalid, axi.bready}, 0);
        if (axi.awvalid && axi.awready) begin
          if (q_aw.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            ea = q_aw.pop_front();
            chk("awaddr", axi.awaddr, ea.addr);
            chk("awlen", axi.awlen, ea.len);
            chk("aw_const", {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0});
          end
          aw_done = 1;
        end
        if (axi.wvalid && axi.wready) begin
          chk("w_before_aw", aw_done, 1);
          beats_seen++;
          if (q_w.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            ew = q_w.pop_front();
            chk("wdata", axi.wdata, ew.data);
            chk("wlast", axi.wlast, ew.last);
            chk("wstrb", axi.wstrb, 4'hF);
          end
          if (axi.wlast) aw_done = 0;
        end
        if (sts_valid) begin
          sts_cnt++;
          outstanding--;
          if (q_sts.size() == 0) chk("sts_unexpected", 1, 0);
          else begin
            es = q_sts.pop_front();
            chk("sts_resp", sts_resp, es.resp);
            if (es.rej) chk("reject_latency", cyc - acc_cyc, 1);
          end
        end
      end
    end
  end

  // AXI RAM slave model with random AW/W stalls and delayed B
  initial begin
    bit aw_hs, w_hs, b_hs, wl, bpend;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int sbase, sbeat;
    bpend = 0; sbase = 0; sbeat = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    forever begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready; a = axi.awaddr;
      w_hs  = axi.wvalid && axi.wready;   wd = axi.wdata; wl = axi.wlast;
      b_hs  = axi.bvalid && axi.bready;
      @(posedge clk); #1;
      if (rst) begin
        bpend = 0; sbeat = 0; axi.bvalid = 1'b0; q_bresp.delete();
      end else begin
        if (aw_hs) begin sbase = int'(a) / 4; sbeat = 0; end
        if (w_hs) begin
          ram[sbase + sbeat] = wd; sbeat++;
          if (wl) bpend = 1;
        end
        if (b_hs) axi.bvalid = 1'b0;
        if (bpend && !axi.bvalid && $urandom_range(0, 2) != 0) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (q_bresp.size() != 0) ? q_bresp.pop_front() : 2'b00;
          bpend = 0;
        end
      end
      axi.awready = ($urandom_range(0, 2) == 0);
      axi.wready  = ($urandom_range(0, 3) != 0);
    end
  end

  // Stream source: holds each beat until accepted, random gaps between beats
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = tvalid && tready;
      @(posedge clk); #1;
      if (rst) begin
        tvalid = 1'b0; q_data.delete();
      end else begin
        if (hs) begin void'(q_data.pop_front()); tvalid = 1'b0; end
        if (!tvalid && q_data.size() != 0 && $urandom_range(0, 3) != 0) begin
          tvalid = 1'b1; tdata = q_data[0];
        end
      end
    end
  end

  initial begin
    int b0, s0, t;
    logic [AW-1:0] ra;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {cmd_ready, axi.awvalid, axi.bready, sts_valid, sts_resp, busy, axi.wvalid, tready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_first_cycle", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_rise", cmd_ready, 1);
    @(posedge clk); #1;

    issue(16'h0010, 0, 2'b00, 2, 1);
    wait_done();
    chk("ram_word4", rd(4), 32'hDEADBEEF);

    b0 = beats_seen; s0 = sts_cnt;
    issue(16'h0100, 15, 2'b00, 1, 1);
    wait_done();
    chk("burst16_beats", beats_seen - b0, 16);
    chk("burst16_sts", sts_cnt - s0, 1);

    issue(16'h0203, 1, 2'b00, 0, 1);
    wait_done();

    s0 = sts_cnt;
    issue(16'h0300, 3, 2'b01, 0, 1);
    issue(16'h0400, 0, 2'b11, 0, 1);
    wait_done();
    chk("b2b_sts", sts_cnt - s0, 2);

    // abandon a len=7 burst partway through its third beat
    b0 = beats_seen;
    issue(16'h8000, 7, 2'b00, 0, 0);
    t = 0;
    while (beats_seen < b0 + 2 && t < 2000) begin @(negedge clk); t++; end
    chk("rst_burst_progress", t < 2000, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_outputs", {axi.awvalid, axi.wvalid, axi.bready, tready, busy, sts_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q_aw.delete(); q_w.delete(); q_sts.delete(); q_data.delete(); q_bresp.delete();
    exp_sts_total--;
    s0 = sts_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("no_sts_after_rst", sts_cnt - s0, 0);
    issue(16'h0500, 0, 2'b00, 0, 1);
    wait_done();

    issue(16'h0FF8, 3, 2'b00, 0, 1);
    wait_done();

    b0 = beats_seen;
    issue(16'h2000, 255, 2'b00, 0, 1);
    wait_done();
    chk("len255_beats", beats_seen - b0, 256);

    for (int n = 0; n < 24; n++) begin
      ra = AW'($urandom_range(16'h1000, 16'h7FFF));
      issue(ra, $urandom_range(0, 15), 2'($urandom), 0, 1);
      if ($urandom_range(0, 1) != 0) wait_done();
    end
    wait_done();

    foreach (exp_mem[k]) chk("ram_word", rd(k), exp_mem[k]);
    chk("sts_total", sts_cnt, exp_sts_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
